maze_solver_ctrl: RTL and testbench
===================================

Name: maze_solver_ctrl

Overview:
- Depth-first-search controller that drives the 16x16 single-bit maze memory to find a path from a start cell to a goal cell.
- Memory cell convention: 0 = free, 1 = wall or already visited.
- Keeps an internal direction stack, marks visited cells by writing 1, and backtracks on dead ends.
- On success, streams the found move list to a consumer (display/path checker) over a valid/ready handshake.

Parameters:
- START_X, 0, start column (0..15)
- START_Y, 0, start row (0..15)
- GOAL_X, 15, goal column
- GOAL_Y, 15, goal row

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_x  out  4  memory column address
- mem_y  out  4  memory row address
- mem_din  out  1  write data to memory (always 1)
- mem_dout  in  1  read data; valid the cycle after mem_rd
- busy  out  1  high from start accept until DONE/FAIL
- done  out  1  path found and replay complete; held until next start
- fail  out  1  no path exists; held until next start
- path_len  out  9  number of moves on the found path (0..255)
- move_valid  out  1  replay element valid
- move_dir  out  2  replay direction: 0=R(x+1), 1=D(y+1), 2=L(x-1), 3=U(y-1)
- move_ready  in  1  consumer accepts replay element

Behaviour:
- Reset (rst low at clk edge):
  - All outputs are 0.
  - State is IDLE; stack pointer sp=0; position = (START_X, START_Y).
  - Reset mid-solve aborts immediately. Memory contents are not restored.
- Direction stack: 256 x 2 bits; sp is 9 bits.
- Direction trial order is 0,1,2,3. dir_try is a 3-bit register; a value of 4 means exhausted.
- States:
  - IDLE: on start, position is set to START and sp=0. busy=1. Go to MARK.
  - MARK (1 cycle): mem_wr=1, mem_din=1 at the current position. If position == GOAL, go to REPLAY. Otherwise set dir_try=0 and go to TRY.
  - TRY: if dir_try==4, go to BACKTRACK. Compute the candidate cell. If it is outside 0..15 (no wrap-around), increment dir_try and stay in TRY. Otherwise go to READ.
  - READ (1 cycle): mem_rd=1 with mem_x/mem_y set to the candidate.
  - EVAL: sample mem_dout.
    - 0: push dir_try at stack[sp], increment sp, move to the candidate, go to MARK.
    - 1: increment dir_try, go to TRY.
  - BACKTRACK:
    - sp==0: fail=1, busy=0, go to FAIL.
    - Otherwise decrement sp, pop d, step opposite to d, set dir_try=d+1, go to TRY.
  - REPLAY: path_len=sp. Replay index r runs from 0 up to sp-1, presenting move_valid=1 and move_dir=stack[r].
    - Transfer occurs when move_valid and move_ready are both high. r then advances.
    - move_dir is held stable while move_ready is low.
    - After the last transfer: move_valid=0, done=1, busy=0, go to DONE.
    - sp==0 (start==goal): done asserts with no transfers.
  - DONE/FAIL: hold flags and path_len. A start pulse clears done/fail and restarts; the caller must reload the maze first.
- mem_rd and mem_wr are never asserted in the same cycle. Both are 0 outside READ and MARK.
- The start cell is marked without being checked. A wall at START is overwritten.
- Path length cannot exceed 255, because visited marking bounds the depth.

Test Plan:
1. All-zero maze, start pulse: path_len=30; replay is 15x dir 0 then 15x dir 1; done=1, fail=0; cells row 0 and column 15 read back as 1.
2. Walls at (1,0) and (0,2), otherwise free: the first moves are D then R from (0,1). The path is reached without using (1,0). No move_dir ever leads into a wall (checker model walks the replay).
3. Walls fill column 1 for all rows: exhaustive backtrack; fail=1, done=0, path_len=0, move_valid never asserted; busy falls the same cycle fail rises.
4. Open maze, move_ready low for 5 cycles mid-replay: move_valid and move_dir stay stable throughout; no element is lost or duplicated; total of 30 transfers.
5. rst low for 1 cycle while in EVAL: the next cycle is IDLE with all outputs 0. A new start on the reloaded maze yields the same result as scenario 1.
6. GOAL_X=START_X=GOAL_Y=START_Y=0: start gives one MARK write, then done=1 with path_len=0 and no transfers.

Source files
------------

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze search over an external 16x16 one-bit memory (1 = wall/visited),
// followed by a valid/ready replay of the move list held on the internal direction stack.
module maze_solver_ctrl #(
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [3:0] mem_x,
    output logic [3:0] mem_y,
    output logic       mem_din,
    input  logic       mem_dout,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [8:0] path_len,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready
);
    localparam logic [3:0] SX = 4'(START_X);
    localparam logic [3:0] SY = 4'(START_Y);
    localparam logic [3:0] GX = 4'(GOAL_X);
    localparam logic [3:0] GY = 4'(GOAL_Y);

    typedef enum logic [3:0] {
        S_IDLE, S_MARK, S_TRY, S_READ, S_EVAL, S_BACKTRACK, S_REPLAY, S_DONE, S_FAIL
    } state_t;

    state_t     state;
    logic [3:0] pos_x, pos_y;
    logic [8:0] sp, r;
    logic [2:0] dir_try;
    logic [1:0] stack [0:255];

    logic [4:0] cand_x, cand_y;
    logic       cand_oob;
    logic [8:0] sp_m1, r_p1;
    logic [1:0] pop_d;
    logic [3:0] back_x, back_y;
    logic       push;

    // Candidate neighbour in 5 bits so that stepping off either edge sets bit 4.
    always_comb begin
        cand_x = {1'b0, pos_x};
        cand_y = {1'b0, pos_y};
        case (dir_try[1:0])
            2'd0:    cand_x = {1'b0, pos_x} + 5'd1;
            2'd1:    cand_y = {1'b0, pos_y} + 5'd1;
            2'd2:    cand_x = {1'b0, pos_x} - 5'd1;
            default: cand_y = {1'b0, pos_y} - 5'd1;
        endcase
        cand_oob = cand_x[4] | cand_y[4];
    end

    assign sp_m1 = sp - 9'd1;
    assign r_p1  = r + 9'd1;
    assign pop_d = stack[sp_m1[7:0]];
    assign push  = (state == S_EVAL) && !mem_dout;

    // Backtracking undoes the popped move, so it always lands on an in-range cell.
    always_comb begin
        back_x = pos_x;
        back_y = pos_y;
        case (pop_d)
            2'd0:    back_x = pos_x - 4'd1;
            2'd1:    back_y = pos_y - 4'd1;
            2'd2:    back_x = pos_x + 4'd1;
            default: back_y = pos_y + 4'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && push) stack[sp[7:0]] <= dir_try[1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pos_x      <= SX;
            pos_y      <= SY;
            sp         <= '0;
            r          <= '0;
            dir_try    <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_x      <= '0;
            mem_y      <= '0;
            mem_din    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            path_len   <= '0;
            move_valid <= 1'b0;
            move_dir   <= '0;
        end else begin
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            mem_din <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        pos_x    <= SX;
                        pos_y    <= SY;
                        sp       <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        fail     <= 1'b0;
                        path_len <= '0;
                        mem_wr   <= 1'b1;
                        mem_din  <= 1'b1;
                        mem_x    <= SX;
                        mem_y    <= SY;
                        state    <= S_MARK;
                    end
                end
                S_MARK: begin
                    if (pos_x == GX && pos_y == GY) begin
                        r        <= '0;
                        path_len <= sp;
                        state    <= S_REPLAY;
                    end else begin
                        dir_try <= '0;
                        state   <= S_TRY;
                    end
                end
                S_TRY: begin
                    if (dir_try[2]) begin
                        state <= S_BACKTRACK;
                    end else if (cand_oob) begin
                        dir_try <= dir_try + 3'd1;
                    end else begin
                        mem_rd <= 1'b1;
                        mem_x  <= cand_x[3:0];
                        mem_y  <= cand_y[3:0];
                        state  <= S_READ;
                    end
                end
                S_READ: state <= S_EVAL;
                S_EVAL: begin
                    if (!mem_dout) begin
                        sp      <= sp + 9'd1;
                        pos_x   <= cand_x[3:0];
                        pos_y   <= cand_y[3:0];
                        mem_wr  <= 1'b1;
                        mem_din <= 1'b1;
                        mem_x   <= cand_x[3:0];
                        mem_y   <= cand_y[3:0];
                        state   <= S_MARK;
                    end else begin
                        dir_try <= dir_try + 3'd1;
                        state   <= S_TRY;
                    end
                end
                S_BACKTRACK: begin
                    if (sp == 9'd0) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FAIL;
                    end else begin
                        sp      <= sp_m1;
                        pos_x   <= back_x;
                        pos_y   <= back_y;
                        dir_try <= {1'b0, pop_d} + 3'd1;
                        state   <= S_TRY;
                    end
                end
                // Stream: an element moves when move_valid && move_ready at a clock edge;
                // move_dir is held while the consumer stalls.
                S_REPLAY: begin
                    if (!move_valid) begin
                        if (r == sp) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            move_valid <= 1'b1;
                            move_dir   <= stack[r[7:0]];
                        end
                    end else if (move_ready) begin
                        r <= r_p1;
                        if (r_p1 == sp) begin
                            move_valid <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            move_dir <= stack[r_p1[7:0]];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Bench for maze_solver_ctrl: behavioural memory, replay monitor and a queue-based DFS reference.
module tb_maze_solver_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, mem_rd, mem_wr, mem_din, mem_dout, busy, done, fail;
    logic       move_valid, move_ready;
    logic [3:0] mem_x, mem_y;
    logic [8:0] path_len;
    logic [1:0] move_dir;

    logic       start_b, b_rd, b_wr, b_din, b_dout, b_busy, b_done, b_fail, b_valid, b_ready;
    logic [3:0] b_x, b_y;
    logic [8:0] b_len;
    logic [1:0] b_dir;

    maze_solver_ctrl #(.START_X(0), .START_Y(0), .GOAL_X(15), .GOAL_Y(15)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_x(mem_x), .mem_y(mem_y), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .done(done), .fail(fail), .path_len(path_len),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready)
    );

    maze_solver_ctrl #(.START_X(0), .START_Y(0), .GOAL_X(0), .GOAL_Y(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mem_rd(b_rd), .mem_wr(b_wr),
        .mem_x(b_x), .mem_y(b_y), .mem_din(b_din), .mem_dout(b_dout),
        .busy(b_busy), .done(b_done), .fail(b_fail), .path_len(b_len),
        .move_valid(b_valid), .move_dir(b_dir), .move_ready(b_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Maze memory: maze[y][x]; load_maze is also the untouched picture the model starts from.
    logic maze      [0:15][0:15];
    logic load_maze [0:15][0:15];
    bit   vis       [0:15][0:15];
    logic load_req;

    always @(posedge clk) begin
        if (load_req) begin
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++) maze[y][x] <= load_maze[y][x];
        end else if (mem_wr) begin
            maze[mem_y][mem_x] <= mem_din;
        end
        if (mem_rd) mem_dout <= maze[mem_y][mem_x];
    end

    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];
    int   stall_seen, stab_err, rdwr_err, b_wr_cnt, b_xfers;
    bit   valid_seen;
    logic prev_valid, prev_ready;
    logic [1:0] prev_dir;
    logic mon_clear;

    always @(negedge clk) begin
        if (mon_clear) begin
            got_q.delete();
            stall_seen = 0; stab_err = 0; rdwr_err = 0; b_wr_cnt = 0; b_xfers = 0;
            valid_seen = 0; prev_valid = 0; prev_ready = 0; prev_dir = 0;
        end else begin
            if (move_valid && move_ready) got_q.push_back(move_dir);
            if (move_valid && !move_ready) stall_seen++;
            if (prev_valid && !prev_ready && (!move_valid || move_dir != prev_dir)) stab_err++;
            if (mem_rd && mem_wr) rdwr_err++;
            if (move_valid) valid_seen = 1;
            if (b_wr) b_wr_cnt++;
            if (b_valid && b_ready) b_xfers++;
            prev_valid = move_valid;
            prev_ready = move_ready;
            prev_dir   = move_dir;
        end
    end

    int stall_at = -1;
    bit rand_ready = 0;
    int stall_cnt = 0;
    bit stall_done = 0;

    always @(posedge clk) begin
        #2;
        if (mon_clear) begin
            stall_cnt = 0;
            stall_done = 0;
        end else if (stall_at >= 0 && !stall_done && got_q.size() == stall_at) begin
            stall_cnt = 5;
            stall_done = 1;
        end
        if (stall_cnt > 0) begin
            move_ready = 1'b0;
            stall_cnt--;
        end else begin
            move_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_grid();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) load_maze[y][x] = 1'b0;
    endtask

    task automatic load_grid();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clear = 1'b1;
        @(posedge clk); @(negedge clk); #1 mon_clear = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {mem_rd, mem_wr, mem_x, mem_y, mem_din, busy, done, fail,
                    path_len, move_valid, move_dir}, 0);
    endtask

    task automatic run_solve(input string tag);
        bit prev_busy;
        bit ended;
        clear_mon();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        prev_busy = 1;
        ended = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done || fail) begin
                ended = 1;
                break;
            end
            prev_busy = busy;
        end
        if (!ended) begin
            check($sformatf("%s_timeout", tag), 1, 0);
        end else begin
            check($sformatf("%s_busy_at_end", tag), busy, 0);
            check($sformatf("%s_busy_before_end", tag), prev_busy, 1);
        end
        @(posedge clk); #1;
    endtask

    // Reference DFS: per-level "next direction" queue plus a path queue of moves taken.
    task automatic model_solve(output bit found);
        int dx[4] = '{1, 0, -1, 0};
        int dy[4] = '{0, 1, 0, -1};
        int path[$];
        int nxt[$];
        int px, py, nx, ny, d;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) vis[y][x] = load_maze[y][x];
        px = 0; py = 0;
        vis[py][px] = 1;
        nxt.push_back(0);
        found = 0;
        while (!found && nxt.size() > 0) begin
            if (px == 15 && py == 15) begin
                found = 1;
            end else if (nxt[nxt.size()-1] == 4) begin
                void'(nxt.pop_back());
                if (path.size() > 0) begin
                    d = path.pop_back();
                    px -= dx[d];
                    py -= dy[d];
                end
            end else begin
                d = nxt[nxt.size()-1];
                nxt[nxt.size()-1] = d + 1;
                nx = px + dx[d];
                ny = py + dy[d];
                if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[ny][nx]) begin
                    vis[ny][nx] = 1;
                    path.push_back(d);
                    nxt.push_back(0);
                    px = nx;
                    py = ny;
                end
            end
        end
        exp_q.delete();
        if (found) foreach (path[i]) exp_q.push_back(2'(path[i]));
    endtask

    task automatic compare_model(input string tag);
        bit found;
        int bad;
        model_solve(found);
        check($sformatf("%s_done", tag), done, found);
        check($sformatf("%s_fail", tag), fail, !found);
        check($sformatf("%s_path_len", tag), path_len, exp_q.size());
        check($sformatf("%s_xfers", tag), got_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check($sformatf("%s_move_seq", tag), bad, 0);
        bad = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (maze[y][x] !== logic'(vis[y][x])) bad++;
        check($sformatf("%s_mem_marks", tag), bad, 0);
        check($sformatf("%s_rd_wr_overlap", tag), rdwr_err, 0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, n, px, py;
        bit b_ended;
        rst = 1'b0; start = 1'b0; start_b = 1'b0; b_dout = 1'b0; b_ready = 1'b1;
        load_req = 1'b0; mon_clear = 1'b1;
        clear_grid();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_outputs");
        check("reset_b_flags", {b_busy, b_done, b_fail, b_valid, b_wr}, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Open maze: 15 moves right then 15 down.
        clear_grid(); load_grid();
        run_solve("s1");
        compare_model("s1");
        check("s1_len_30", path_len, 30);
        bad = 0;
        foreach (got_q[i]) if (got_q[i] !== ((i < 15) ? 2'd0 : 2'd1)) bad++;
        check("s1_r_then_d", bad, 0);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (maze[0][k] !== 1'b1) bad++;
            if (maze[k][15] !== 1'b1) bad++;
        end
        check("s1_edge_marked", bad, 0);

        // Walls at (1,0) and (0,2).
        clear_grid(); load_maze[0][1] = 1'b1; load_maze[2][0] = 1'b1; load_grid();
        run_solve("s2");
        compare_model("s2");
        check("s2_first_down", (got_q.size() > 1) ? got_q[0] : 2'bxx, 1);
        check("s2_second_right", (got_q.size() > 1) ? got_q[1] : 2'bxx, 0);
        px = 0; py = 0; bad = 0;
        foreach (got_q[i]) begin
            case (got_q[i])
                2'd0: px++;
                2'd1: py++;
                2'd2: px--;
                default: py--;
            endcase
            if (px < 0 || px > 15 || py < 0 || py > 15) bad++;
            else if (load_maze[py][px]) bad++;
        end
        check("s2_walk_no_wall", bad, 0);
        check("s2_walk_end", px * 16 + py, 15 * 16 + 15);

        // Column 1 fully walled: no path.
        clear_grid();
        for (int y = 0; y < 16; y++) load_maze[y][1] = 1'b1;
        load_grid();
        run_solve("s3");
        compare_model("s3");
        check("s3_fail", fail, 1);
        check("s3_path_len_zero", path_len, 0);
        check("s3_no_valid", valid_seen, 0);

        // Consumer stalls 5 cycles after the 10th transfer.
        clear_grid(); load_grid();
        stall_at = 10;
        run_solve("s4");
        stall_at = -1;
        compare_model("s4");
        check("s4_stable_during_stall", stab_err, 0);
        check("s4_stall_observed", stall_seen >= 5, 1);
        check("s4_xfers_30", got_q.size(), 30);

        // Reset while evaluating a read, then a clean rerun.
        clear_grid(); load_grid();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        for (int i = 0; i < 1000 && n < 5; i++) begin
            @(negedge clk);
            if (mem_rd) n++;
        end
        check("s5_reached_read", n, 5);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("s5_abort_outputs");
        repeat (3) @(negedge clk);
        check("s5_stays_idle", {busy, mem_wr, mem_rd}, 0);
        clear_grid(); load_grid();
        run_solve("s5");
        compare_model("s5");
        check("s5_len_30", path_len, 30);

        // Start equals goal.
        clear_mon();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        b_ended = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_done || b_fail) begin
                b_ended = 1;
                break;
            end
        end
        check("s6_ended", b_ended, 1);
        check("s6_done", b_done, 1);
        check("s6_fail", b_fail, 0);
        check("s6_path_len", b_len, 0);
        check("s6_one_write", b_wr_cnt, 1);
        check("s6_no_xfers", b_xfers, 0);
        check("s6_busy_low", b_busy, 0);

        // Random mazes with a jittery consumer.
        rand_ready = 1;
        for (int k = 0; k < 6; k++) begin
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    load_maze[y][x] = ($urandom_range(0, 99) < 28);
            load_grid();
            run_solve($sformatf("rnd%0d", k));
            compare_model($sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_stable", k), stab_err, 0);
        end
        rand_ready = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
